// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for the rename stage.
//   Up to two tags handed out per cycle (allocation) and up to two returned per
//   cycle at commit. A commit head pointer trails the allocation head so that a
//   flush can reclaim every tag given to squashed instructions in one cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 squash uncommitted instructions (head <- commit head)
//   free_list_valid[1:0]  allocation request per rename slot
//   rd_phy_new_0/1        tags offered to slot 0 / slot 1 (combinational)
//   commit_alloc_valid    per commit slot: instruction had allocated a tag
//   free_valid, free_phy_0/1  tags returned at commit
//   free_count            allocatable tags (tail - head)
//   alloc_stall           fewer than two tags available
//   underflow / overflow  one-cycle pulses for a dropped request / return
module free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6,
  localparam int DEPTH    = PHY_REGS - ARCH_REGS,
  localparam int IW       = $clog2(DEPTH),
  localparam int PW       = IW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           free_list_valid,
  output logic [PHY_WIDTH-1:0] rd_phy_new_0,
  output logic [PHY_WIDTH-1:0] rd_phy_new_1,
  input  logic [1:0]           commit_alloc_valid,
  input  logic [1:0]           free_valid,
  input  logic [PHY_WIDTH-1:0] free_phy_0,
  input  logic [PHY_WIDTH-1:0] free_phy_1,
  output logic [PW-1:0]        free_count,
  output logic                 alloc_stall,
  output logic                 underflow,
  output logic                 overflow
);

  logic [PHY_WIDTH-1:0] fifo [DEPTH];
  logic [PW-1:0]        head, tail, commit_head;

  logic [1:0]    n_alloc, n_commit, n_free;
  logic [PW-1:0] head_p1, head_nxt, commit_nxt, tail_p1, cnt_after;
  logic          alloc_ok, keep0, keep1, push, uf_nxt, ovf_nxt;

  assign free_count  = tail - head;
  assign alloc_stall = free_count < PW'(2);

  assign n_alloc  = {1'b0, free_list_valid[0]} + {1'b0, free_list_valid[1]};
  assign n_commit = {1'b0, commit_alloc_valid[0]} + {1'b0, commit_alloc_valid[1]};

  // Slot 1 alone takes the head tag; with slot 0 active it takes the next one.
  assign head_p1      = head + PW'(1);
  assign rd_phy_new_0 = fifo[head[IW-1:0]];
  assign rd_phy_new_1 = free_list_valid[0] ? fifo[head_p1[IW-1:0]] : fifo[head[IW-1:0]];

  assign commit_nxt = commit_head + PW'(n_commit);
  assign alloc_ok   = PW'(n_alloc) <= free_count;

  // Flush rewinds head to the post-commit point and swallows this cycle's requests.
  always_comb begin
    head_nxt = head;
    uf_nxt   = 1'b0;
    if (flush)         head_nxt = commit_nxt;
    else if (alloc_ok) head_nxt = head + PW'(n_alloc);
    else               uf_nxt   = 1'b1;
  end

  // Tag 0 is the hardwired x0 mapping and never re-enters the list.
  assign keep0     = free_valid[0] && (free_phy_0 != '0);
  assign keep1     = free_valid[1] && (free_phy_1 != '0);
  assign n_free    = {1'b0, keep0} + {1'b0, keep1};
  assign cnt_after = tail - head_nxt;
  // Capacity is judged against occupancy after this cycle's head move; the
  // whole return is dropped rather than split.
  assign ovf_nxt   = (n_free != 2'd0) &&
                     (({1'b0, cnt_after} + (PW+1)'(n_free)) > (PW+1)'(DEPTH));
  assign push      = !ovf_nxt;
  assign tail_p1   = tail + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= PHY_WIDTH'(ARCH_REGS + i);
      head        <= '0;
      commit_head <= '0;
      tail        <= PW'(DEPTH);
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      head        <= head_nxt;
      commit_head <= commit_nxt;
      underflow   <= uf_nxt;
      overflow    <= ovf_nxt;
      if (push) begin
        // Compact: first surviving tag goes at tail, the second right behind.
        if (keep0 || keep1) fifo[tail[IW-1:0]] <= keep0 ? free_phy_0 : free_phy_1;
        if (keep0 && keep1) fifo[tail_p1[IW-1:0]] <= free_phy_1;
        tail <= tail + PW'(n_free);
      end
    end
  end

endmodule
